// File: rtl/float_classify_stage_pkg.sv
// Shared definitions for the float classification stage: class-mask bit
// positions in RISC-V fclass order and the operand word width helper.
package float_pkg;

  localparam int CLASS_WIDTH    = 10;
  localparam int CLASS_NEG_INF  = 0;
  localparam int CLASS_NEG_NORM = 1;
  localparam int CLASS_NEG_SUB  = 2;
  localparam int CLASS_NEG_ZERO = 3;
  localparam int CLASS_POS_ZERO = 4;
  localparam int CLASS_POS_SUB  = 5;
  localparam int CLASS_POS_NORM = 6;
  localparam int CLASS_POS_INF  = 7;
  localparam int CLASS_SNAN     = 8;
  localparam int CLASS_QNAN     = 9;

  typedef logic [CLASS_WIDTH-1:0] class_mask_t;

  function automatic int float_width(input int exponent_width, input int mantissa_width);
    return exponent_width + mantissa_width + 1;
  endfunction

endpackage

// File: rtl/float_classify_stage_if.sv
// Upstream/downstream stream channels of the classification stage.
interface float_classify_stage_if #(
  parameter int W = 32
);
  import float_pkg::*;

  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_data;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_data;
  class_mask_t    out_class;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_class
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_class
  );
endinterface

// File: rtl/float_classify_stage_is_special.sv
// Decodes special encodings of a {sign, exponent, mantissa} word, honouring
// small formats that reserve no infinity and/or no NaN encodings.
module is_special_float #(
  parameter int EXPONENT_WIDTH = 8,
  parameter int MANTISSA_WIDTH = 23
) (
  input  logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] data_i,
  output logic                                   is_inf_o,
  output logic                                   is_zero_o,
  output logic                                   is_subnormal_o,
  output logic                                   is_snan_o,
  output logic                                   is_qnan_o
);
  localparam bit FMT_NO_SPECIALS = ((EXPONENT_WIDTH == 2) && (MANTISSA_WIDTH == 3)) ||
                                   ((EXPONENT_WIDTH == 3) && (MANTISSA_WIDTH == 2)) ||
                                   ((EXPONENT_WIDTH == 2) && (MANTISSA_WIDTH == 1));
  localparam bit FMT_E4M3        = (EXPONENT_WIDTH == 4) && (MANTISSA_WIDTH == 3);
  localparam bit HAS_INF         = !(FMT_NO_SPECIALS || FMT_E4M3);
  localparam bit HAS_NAN         = !FMT_NO_SPECIALS;

  logic [EXPONENT_WIDTH-1:0] exp_s;
  logic [MANTISSA_WIDTH-1:0] man_s;
  logic                      exp_max_s;
  logic                      exp_zero_s;
  logic                      man_zero_s;
  logic                      nan_s;

  assign exp_s      = data_i[EXPONENT_WIDTH+MANTISSA_WIDTH-1:MANTISSA_WIDTH];
  assign man_s      = data_i[MANTISSA_WIDTH-1:0];
  assign exp_max_s  = &exp_s;
  assign exp_zero_s = ~|exp_s;
  assign man_zero_s = ~|man_s;

  // E4M3 spends only the all-ones mantissa on NaN; the rest of its top binade is normal.
  assign nan_s          = HAS_NAN && exp_max_s && (FMT_E4M3 ? (&man_s) : !man_zero_s);
  assign is_inf_o       = HAS_INF && exp_max_s && man_zero_s;
  assign is_zero_o      = exp_zero_s && man_zero_s;
  assign is_subnormal_o = exp_zero_s && !man_zero_s;
  // Mantissa MSB set marks the signaling variant in this datapath's encoding.
  assign is_snan_o      = nan_s && man_s[MANTISSA_WIDTH-1];
  assign is_qnan_o      = nan_s && !man_s[MANTISSA_WIDTH-1];
endmodule

// File: rtl/float_classify_stage.sv
// Registered classification stage with a skid buffer, producing an fclass-style
// one-hot mask plus sticky exception flags and a saturating special count.
module float_classify_stage
  import float_pkg::*;
#(
  parameter int EXPONENT_WIDTH = 8,
  parameter int MANTISSA_WIDTH = 23,
  parameter int COUNT_WIDTH    = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  float_classify_stage_if.slave  bus,
  input  logic                   flags_clear,
  output logic                   flag_nan,
  output logic                   flag_snan,
  output logic                   flag_inf,
  output logic                   flag_subnormal,
  output logic [COUNT_WIDTH-1:0] special_count
);
  localparam int W = float_width(EXPONENT_WIDTH, MANTISSA_WIDTH);

  logic is_inf_s, is_zero_s, is_sub_s, is_snan_s, is_qnan_s;
  logic sign_s, accept_s, transfer_s, special_s;
  class_mask_t class_s;

  logic [W-1:0]     main_data_q, main_data_d, skid_data_q, skid_data_d;
  class_mask_t      main_class_q, main_class_d, skid_class_q, skid_class_d;
  logic             main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
  logic             flag_nan_q, flag_nan_d, flag_snan_q, flag_snan_d;
  logic             flag_inf_q, flag_inf_d, flag_sub_q, flag_sub_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d, count_base_s;

  is_special_float #(
    .EXPONENT_WIDTH (EXPONENT_WIDTH),
    .MANTISSA_WIDTH (MANTISSA_WIDTH)
  ) u_is_special (
    .data_i         (bus.in_data),
    .is_inf_o       (is_inf_s),
    .is_zero_o      (is_zero_s),
    .is_subnormal_o (is_sub_s),
    .is_snan_o      (is_snan_s),
    .is_qnan_o      (is_qnan_s)
  );

  assign sign_s     = bus.in_data[W-1];
  assign accept_s   = bus.in_valid && !skid_valid_q;
  assign transfer_s = main_valid_q && bus.out_ready;
  assign special_s  = is_snan_s || is_qnan_s || is_inf_s || is_sub_s;

  always_comb begin
    class_s = '0;
    if (is_snan_s) begin
      class_s[CLASS_SNAN] = 1'b1;
    end else if (is_qnan_s) begin
      class_s[CLASS_QNAN] = 1'b1;
    end else if (is_inf_s) begin
      class_s[sign_s ? CLASS_NEG_INF : CLASS_POS_INF] = 1'b1;
    end else if (is_zero_s) begin
      class_s[sign_s ? CLASS_NEG_ZERO : CLASS_POS_ZERO] = 1'b1;
    end else if (is_sub_s) begin
      class_s[sign_s ? CLASS_NEG_SUB : CLASS_POS_SUB] = 1'b1;
    end else begin
      class_s[sign_s ? CLASS_NEG_NORM : CLASS_POS_NORM] = 1'b1;
    end
  end

  // Skid can only be occupied while main is stalled, so accept and skid drain never coincide.
  always_comb begin
    main_data_d  = main_data_q;
    main_class_d = main_class_q;
    main_valid_d = main_valid_q;
    skid_data_d  = skid_data_q;
    skid_class_d = skid_class_q;
    skid_valid_d = skid_valid_q;
    if (transfer_s && skid_valid_q) begin
      main_data_d  = skid_data_q;
      main_class_d = skid_class_q;
      skid_valid_d = 1'b0;
    end else if (transfer_s) begin
      main_valid_d = 1'b0;
    end else begin
      main_valid_d = main_valid_q;
    end
    if (accept_s && (!main_valid_q || transfer_s)) begin
      main_data_d  = bus.in_data;
      main_class_d = class_s;
      main_valid_d = 1'b1;
    end else if (accept_s) begin
      skid_data_d  = bus.in_data;
      skid_class_d = class_s;
      skid_valid_d = 1'b1;
    end else begin
      skid_valid_d = skid_valid_d;
    end
  end

  // A clear coinciding with an accept applies first, so the new word still registers.
  always_comb begin
    flag_nan_d   = flags_clear ? 1'b0 : flag_nan_q;
    flag_snan_d  = flags_clear ? 1'b0 : flag_snan_q;
    flag_inf_d   = flags_clear ? 1'b0 : flag_inf_q;
    flag_sub_d   = flags_clear ? 1'b0 : flag_sub_q;
    count_base_s = flags_clear ? '0 : count_q;
    count_d      = count_base_s;
    if (accept_s) begin
      flag_nan_d  = flag_nan_d  | class_s[CLASS_SNAN] | class_s[CLASS_QNAN];
      flag_snan_d = flag_snan_d | class_s[CLASS_SNAN];
      flag_inf_d  = flag_inf_d  | class_s[CLASS_NEG_INF] | class_s[CLASS_POS_INF];
      flag_sub_d  = flag_sub_d  | class_s[CLASS_NEG_SUB] | class_s[CLASS_POS_SUB];
      if (special_s && !(&count_base_s)) begin
        count_d = count_base_s + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
      end else begin
        count_d = count_base_s;
      end
    end else begin
      count_d = count_base_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_data_q  <= '0;
      main_class_q <= '0;
      main_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_class_q <= '0;
      skid_valid_q <= 1'b0;
      flag_nan_q   <= 1'b0;
      flag_snan_q  <= 1'b0;
      flag_inf_q   <= 1'b0;
      flag_sub_q   <= 1'b0;
      count_q      <= '0;
    end else begin
      main_data_q  <= main_data_d;
      main_class_q <= main_class_d;
      main_valid_q <= main_valid_d;
      skid_data_q  <= skid_data_d;
      skid_class_q <= skid_class_d;
      skid_valid_q <= skid_valid_d;
      flag_nan_q   <= flag_nan_d;
      flag_snan_q  <= flag_snan_d;
      flag_inf_q   <= flag_inf_d;
      flag_sub_q   <= flag_sub_d;
      count_q      <= count_d;
    end
  end

  assign bus.in_ready   = !skid_valid_q;
  assign bus.out_valid  = main_valid_q;
  assign bus.out_data   = main_data_q;
  assign bus.out_class  = main_class_q;
  assign flag_nan       = flag_nan_q;
  assign flag_snan      = flag_snan_q;
  assign flag_inf       = flag_inf_q;
  assign flag_subnormal = flag_sub_q;
  assign special_count  = count_q;
endmodule

// File: tb/tb_float_classify_stage.sv
// Directed bench: FP32, E4M3 and a 2-bit-counter instance of float_classify_stage.
module tb_float_classify_stage;
  import float_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_mis = 0;

  always #5 clk = ~clk;

  float_classify_stage_if #(.W(32)) f_if ();
  float_classify_stage_if #(.W(8))  e_if ();
  float_classify_stage_if #(.W(32)) c_if ();

  logic        f_clr, f_nan, f_snan, f_inf, f_sub;
  logic [15:0] f_cnt;
  logic        e_clr, e_nan, e_snan, e_inf, e_sub;
  logic [15:0] e_cnt;
  logic        c_clr, c_nan, c_snan, c_inf, c_sub;
  logic [1:0]  c_cnt;

  float_classify_stage #(.EXPONENT_WIDTH(8), .MANTISSA_WIDTH(23), .COUNT_WIDTH(16)) u_fp32 (
    .clk(clk), .rst_n(rst_n), .bus(f_if), .flags_clear(f_clr), .flag_nan(f_nan),
    .flag_snan(f_snan), .flag_inf(f_inf), .flag_subnormal(f_sub), .special_count(f_cnt));

  float_classify_stage #(.EXPONENT_WIDTH(4), .MANTISSA_WIDTH(3), .COUNT_WIDTH(16)) u_e4m3 (
    .clk(clk), .rst_n(rst_n), .bus(e_if), .flags_clear(e_clr), .flag_nan(e_nan),
    .flag_snan(e_snan), .flag_inf(e_inf), .flag_subnormal(e_sub), .special_count(e_cnt));

  float_classify_stage #(.EXPONENT_WIDTH(8), .MANTISSA_WIDTH(23), .COUNT_WIDTH(2)) u_cw2 (
    .clk(clk), .rst_n(rst_n), .bus(c_if), .flags_clear(c_clr), .flag_nan(c_nan),
    .flag_snan(c_snan), .flag_inf(c_inf), .flag_subnormal(c_sub), .special_count(c_cnt));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [31:0] fvec [5] = '{32'h7F800000, 32'hFF800000, 32'h00000001, 32'h80000000, 32'h3F800000};
  logic [31:0] fcls [5] = '{32'h080, 32'h001, 32'h020, 32'h008, 32'h040};
  logic [7:0]  evec [3] = '{8'h7F, 8'h78, 8'hF8};
  logic [31:0] ecls [3] = '{32'h100, 32'h040, 32'h002};
  logic [31:0] bp_d [3] = '{32'h3F800000, 32'hBF800000, 32'h00000000};
  logic [31:0] bp_c [3] = '{32'h040, 32'h002, 32'h010};

  initial begin
    f_if.in_valid = 1'b0; f_if.in_data = 32'h0; f_if.out_ready = 1'b1; f_clr = 1'b0;
    e_if.in_valid = 1'b0; e_if.in_data = 8'h0;  e_if.out_ready = 1'b1; e_clr = 1'b0;
    c_if.in_valid = 1'b0; c_if.in_data = 32'h0; c_if.out_ready = 1'b1; c_clr = 1'b0;

    // Reset state
    #12;
    check_eq("rst_out_valid", 32'(f_if.out_valid), 32'd0);
    check_eq("rst_in_ready", 32'(f_if.in_ready), 32'd1);
    check_eq("rst_out_class", 32'(f_if.out_class), 32'd0);
    check_eq("rst_out_data", f_if.out_data, 32'd0);
    check_eq("rst_flags", 32'({f_nan, f_snan, f_inf, f_sub}), 32'd0);
    check_eq("rst_count", 32'(f_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // FP32 stream at full throughput, one cycle latency
    for (int i = 0; i <= 5; i++) begin
      @(negedge clk);
      if (i > 0) begin
        check_eq("fp_stream_valid", 32'(f_if.out_valid), 32'd1);
        check_eq("fp_stream_class", 32'(f_if.out_class), fcls[i-1]);
        check_eq("fp_stream_data", f_if.out_data, fvec[i-1]);
        check_eq("fp_stream_ready", 32'(f_if.in_ready), 32'd1);
      end
      if (i < 5) begin
        f_if.in_valid = 1'b1;
        f_if.in_data  = fvec[i];
      end else begin
        f_if.in_valid = 1'b0;
      end
    end
    check_eq("fp_flag_inf", 32'(f_inf), 32'd1);
    check_eq("fp_flag_sub", 32'(f_sub), 32'd1);
    check_eq("fp_flag_nan0", 32'(f_nan), 32'd0);
    check_eq("fp_count3", 32'(f_cnt), 32'd3);
    @(negedge clk);
    check_eq("fp_drained", 32'(f_if.out_valid), 32'd0);

    // NaN variants
    f_if.in_valid = 1'b1; f_if.in_data = 32'h7FC00000;
    @(negedge clk);
    f_if.in_valid = 1'b0;
    check_eq("fp_nan_msb_class", 32'(f_if.out_class), 32'h100);
    check_eq("fp_flag_snan", 32'(f_snan), 32'd1);
    check_eq("fp_flag_nan", 32'(f_nan), 32'd1);
    f_if.in_valid = 1'b1; f_if.in_data = 32'h7F800001;
    @(negedge clk);
    f_if.in_valid = 1'b0;
    check_eq("fp_nan_lsb_class", 32'(f_if.out_class), 32'h200);
    check_eq("fp_count5", 32'(f_cnt), 32'd5);

    // Backpressure: A to main, B to skid, C held off
    @(negedge clk);
    f_if.out_ready = 1'b0;
    f_if.in_valid = 1'b1; f_if.in_data = bp_d[0];
    @(negedge clk);
    f_if.in_data = bp_d[1];
    @(negedge clk);
    check_eq("bp_in_ready_low", 32'(f_if.in_ready), 32'd0);
    f_if.in_data = bp_d[2];
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_eq("bp_stall_ready", 32'(f_if.in_ready), 32'd0);
      check_eq("bp_stall_data", f_if.out_data, bp_d[0]);
      check_eq("bp_stall_class", 32'(f_if.out_class), bp_c[0]);
    end
    f_if.out_ready = 1'b1;
    for (int k = 1; k < 3; k++) begin
      @(negedge clk);
      check_eq("bp_order_valid", 32'(f_if.out_valid), 32'd1);
      check_eq("bp_order_data", f_if.out_data, bp_d[k]);
      check_eq("bp_order_class", 32'(f_if.out_class), bp_c[k]);
    end
    f_if.in_valid = 1'b0;
    @(negedge clk);
    check_eq("bp_no_dup", 32'(f_if.out_valid), 32'd0);

    // E4M3 encodings
    for (int i = 0; i <= 3; i++) begin
      @(negedge clk);
      if (i > 0) begin
        check_eq("e4m3_class", 32'(e_if.out_class), ecls[i-1]);
        check_eq("e4m3_data", 32'(e_if.out_data), 32'(evec[i-1]));
      end
      if (i < 3) begin
        e_if.in_valid = 1'b1;
        e_if.in_data  = evec[i];
      end else begin
        e_if.in_valid = 1'b0;
      end
    end
    check_eq("e4m3_flag_snan", 32'(e_snan), 32'd1);
    check_eq("e4m3_flag_inf", 32'(e_inf), 32'd0);

    // Saturating 2-bit counter and clear behaviour
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      c_if.in_valid = 1'b1; c_if.in_data = 32'h00000001;
    end
    @(negedge clk);
    c_if.in_valid = 1'b0;
    check_eq("cw2_saturate", 32'(c_cnt), 32'd3);
    check_eq("cw2_flag_sub", 32'(c_sub), 32'd1);
    c_clr = 1'b1;
    @(negedge clk);
    c_clr = 1'b0;
    check_eq("cw2_clr_count", 32'(c_cnt), 32'd0);
    check_eq("cw2_clr_flags", 32'({c_nan, c_snan, c_inf, c_sub}), 32'd0);
    c_clr = 1'b1; c_if.in_valid = 1'b1; c_if.in_data = 32'h7F800001;
    @(negedge clk);
    c_clr = 1'b0; c_if.in_valid = 1'b0;
    check_eq("cw2_clr_set_count", 32'(c_cnt), 32'd1);
    check_eq("cw2_clr_set_nan", 32'(c_nan), 32'd1);
    check_eq("cw2_clr_set_class", 32'(c_if.out_class), 32'h200);

    // Reset with main and skid both full
    f_if.out_ready = 1'b0;
    f_if.in_valid = 1'b1; f_if.in_data = 32'h40000000;
    @(negedge clk);
    f_if.in_data = 32'h40400000;
    @(negedge clk);
    f_if.in_valid = 1'b0;
    check_eq("rst2_full", 32'(f_if.in_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst2_out_valid", 32'(f_if.out_valid), 32'd0);
    check_eq("rst2_in_ready", 32'(f_if.in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    f_if.out_ready = 1'b1;
    @(negedge clk);
    check_eq("rst2_no_stale", 32'(f_if.out_valid), 32'd0);
    f_if.in_valid = 1'b1; f_if.in_data = 32'hFF800000;
    @(negedge clk);
    f_if.in_valid = 1'b0;
    check_eq("rst2_next_valid", 32'(f_if.out_valid), 32'd1);
    check_eq("rst2_next_class", 32'(f_if.out_class), 32'h001);
    check_eq("rst2_next_data", f_if.out_data, 32'hFF800000);
    @(negedge clk);
    check_eq("rst2_single", 32'(f_if.out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule

// File: doc/float_classify_stage.md
Name: float_classify_stage

Overview:
- Registered, stream-handshaked classification stage for a parametrised float operand word.
- Sits directly downstream of operand capture and feeds the FP datapath. It instantiates is_special_float and converts its flags into a 10-bit one-hot class mask, in the same bit order as RISC-V fclass.
- Keeps sticky exception-summary flags and a saturating count of special operands for CSR readout.

Parameters:
- EXPONENT_WIDTH, 8: exponent field width.
- MANTISSA_WIDTH, 23: mantissa field width, hidden bit excluded.
- COUNT_WIDTH, 16: width of the saturating special-operand counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream word valid.
- in_ready  out  1  stage can accept a word.
- in_data  in  W=EXPONENT_WIDTH+MANTISSA_WIDTH+1  {sign, exponent, mantissa}.
- out_valid  out  1  output word valid.
- out_ready  in  1  downstream accepts.
- out_data  out  W  operand, passed through unchanged.
- out_class  out  10  one-hot class mask.
- flags_clear  in  1  synchronous clear of sticky flags and counter.
- flag_nan  out  1  sticky: any NaN accepted.
- flag_snan  out  1  sticky: any signaling NaN accepted.
- flag_inf  out  1  sticky: any infinity accepted.
- flag_subnormal  out  1  sticky: any subnormal accepted.
- special_count  out  COUNT_WIDTH  saturating count of accepted NaN, infinity and subnormal words.

Behaviour:
- Reset (async, rst_n low):
  - out_valid=0, out_data=0, out_class=0.
  - skid register empty, so in_ready=1.
  - All flags 0, special_count=0.
  - Words presented while rst_n is low are not accepted.
- Class mask, computed combinationally from the is_special_float outputs for in_data and registered with the word (s = sign):
  - bit0: s & inf.
  - bit1: s & normal.
  - bit2: s & subnormal.
  - bit3: s & zero.
  - bit4: !s & zero.
  - bit5: !s & subnormal.
  - bit6: !s & normal.
  - bit7: !s & inf.
  - bit8: signaling NaN (sign ignored).
  - bit9: quiet NaN (sign ignored).
  - normal = none of inf, zero, subnormal, sNaN, qNaN.
  - Formats for which is_special_float reports no inf or NaN (E2M3, E3M2, E2M1, and E4M3 inf) classify those encodings as normal. Exactly one bit is always set.
- Handshake:
  - Accept = in_valid & in_ready. Transfer = out_valid & out_ready.
  - in_valid may not be withdrawn before acceptance; out_valid holds until transfer.
  - out_data and out_class are stable while out_valid=1 and out_ready=0.
- Pipeline:
  - Main output register plus one skid register. Latency from accept to out_valid is 1 cycle.
  - in_ready = !skid_valid, taken directly from a flop (no combinational in_ready from out_ready).
  - Accept when main is empty or transferring: the word loads into main.
  - Accept when main is held (out_valid & !out_ready): the word loads into skid.
  - Transfer with skid valid: skid moves to main and skid empties; no new accept that cycle, since in_ready=0.
  - Full throughput of 1 word/cycle when out_ready=1.
  - Ordering is strictly FIFO.
- Sticky flags and counter, updated on accept (not on transfer):
  - flag_nan |= bit8|bit9.
  - flag_snan |= bit8.
  - flag_inf |= bit0|bit7.
  - flag_subnormal |= bit2|bit5.
  - special_count increments when the accepted word is NaN, infinity or subnormal, and saturates at all-ones with no wrap.
  - flags_clear in the same cycle as a special accept: clear first, then set. The flag reflects the new word and the count becomes 1.
  - flags_clear does not affect the data path.
- Asynchronous reset mid-stream drops both buffered words. No output is produced for them after reset.

Decomposition:
- Package float_pkg holds:
  - localparam class-bit indices (CLASS_NEG_INF=0 … CLASS_QNAN=9) and CLASS_WIDTH=10.
  - typedef for the class mask.
  - the function float_width(EXPONENT_WIDTH, MANTISSA_WIDTH).
- Sub-module: is_special_float, instantiated once on in_data.
- The skid logic stays inline; no further sub-module.

Test Plan:
- FP32, out_ready=1, stream 0x7F800000, 0xFF800000, 0x00000001, 0x80000000, 0x3F800000 -> out_class 0x080, 0x001, 0x020, 0x008, 0x040 on consecutive cycles, each one cycle after accept. Afterwards flag_inf=1, flag_subnormal=1, special_count=3.
- FP32 0x7FC00000 -> out_class 0x100, flag_snan=1, flag_nan=1. 0x7F800001 -> 0x200.
- E4M3 (4,3): 0x7F -> 0x100. 0x78 -> 0x040 (no infinity). 0xF8 -> 0x002.
- Backpressure:
  - Hold out_ready=0 while streaming A, B, C. A is in main, B in skid, in_ready drops to 0 and C is held.
  - Release out_ready. Output is A, B, C in order with no loss or duplication, and out_data/out_class are stable while stalled.
- COUNT_WIDTH=2: accept 5 subnormals -> special_count saturates at 3. flags_clear alone -> all flags and count go to 0. flags_clear together with a NaN accept -> count=1, flag_nan=1.
- Assert rst_n low with both registers full -> out_valid=0 and in_ready=1 immediately. After release, the next accepted word appears with the correct class and no stale output.
